// File: rtl/ewrapper_link_rxo_loopback.sv
// Loopback decoder: turns the link transmitter's 72-bit serdes word stream back into eMesh
// transactions. Define ELINK_RXO_ERRCNT_EN to build the saturating violation counter.
module ewrapper_link_rxo_loopback #(
  parameter int unsigned BURST_STRIDE = 8,
  parameter int unsigned ERRCNT_W     = 16
) (
  input  logic                txo_lclk,
  input  logic                reset,
  input  logic [71:0]         tx_in,
  input  logic                err_clr,
  output logic                rxo_emesh_access,
  output logic                rxo_emesh_write,
  output logic [1:0]          rxo_emesh_datamode,
  output logic [3:0]          rxo_emesh_ctrlmode,
  output logic [31:0]         rxo_emesh_dstaddr,
  output logic [31:0]         rxo_emesh_srcaddr,
  output logic [31:0]         rxo_emesh_data,
  output logic                frame_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [7:0]  FrameIdle = 8'h00;
  localparam logic [7:0]  FrameHdr  = 8'h3F;
  localparam logic [7:0]  FrameData = 8'hFF;
  localparam logic [31:0] Stride    = 32'(BURST_STRIDE);

  typedef enum logic [1:0] {StIdle, StHdr, StBurst} state_e;

  logic [71:0] tx_q;
  logic [63:0] word;
  logic [7:0]  frame;

  state_e      state_q, state_d;
  logic        hdr_write_q, hdr_write_d;
  logic [1:0]  hdr_dm_q, hdr_dm_d;
  logic [3:0]  hdr_cm_q, hdr_cm_d;
  logic [31:0] hdr_dst_q, hdr_dst_d;
  logic        hdr_inc0_q, hdr_inc0_d;

  logic        access_q, access_d;
  logic        write_q, write_d;
  logic [1:0]  dm_q, dm_d;
  logic [3:0]  cm_q, cm_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] src_q, src_d;
  logic [31:0] data_q, data_d;
  logic        ferr_q, ferr_d;

  logic        latch_hdr;
  logic        emit;
  logic        viol;

  // Each serdes lane carries one bit of every byte; undo that bit-matrix transpose.
  always_comb begin
    word = '0;
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 8; k++) begin
        word[8*j+k] = tx_q[8*k+j];
      end
    end
  end

  assign frame = tx_q[71:64];

  always_comb begin
    state_d   = state_q;
    latch_hdr = 1'b0;
    emit      = 1'b0;
    viol      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame == FrameHdr) begin
          if (word[0]) begin
            latch_hdr = 1'b1;
            state_d   = StHdr;
          end else begin
            viol = 1'b1;
          end
        end else if (frame != FrameIdle) begin
          viol = 1'b1;
        end
      end
      StHdr: begin
        if (frame == FrameData) begin
          emit    = 1'b1;
          state_d = StBurst;
        end else if (frame == FrameHdr) begin
          // Header without data: flag it but keep the newer header.
          viol      = 1'b1;
          latch_hdr = 1'b1;
        end else begin
          viol    = 1'b1;
          state_d = StIdle;
        end
      end
      StBurst: begin
        if (frame == FrameData) begin
          emit = 1'b1;
        end else if (frame == FrameHdr) begin
          latch_hdr = 1'b1;
          state_d   = StHdr;
        end else if (frame == FrameIdle) begin
          state_d = StIdle;
        end else begin
          viol    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hdr_write_d = hdr_write_q;
    hdr_dm_d    = hdr_dm_q;
    hdr_cm_d    = hdr_cm_q;
    hdr_dst_d   = hdr_dst_q;
    hdr_inc0_d  = hdr_inc0_q;
    if (latch_hdr) begin
      hdr_write_d = word[1];
      hdr_dm_d    = word[3:2];
      hdr_dst_d   = word[35:4];
      hdr_cm_d    = word[39:36];
      hdr_inc0_d  = word[42];
    end
  end

  always_comb begin
    access_d = emit;
    ferr_d   = viol;
    write_d  = write_q;
    dm_d     = dm_q;
    cm_d     = cm_q;
    dst_d    = dst_q;
    src_d    = src_q;
    data_d   = data_q;
    if (emit) begin
      write_d = hdr_write_q;
      dm_d    = hdr_dm_q;
      cm_d    = hdr_cm_q;
      src_d   = word[31:0];
      data_d  = word[63:32];
      // dst_q still holds the previous beat's address while bursting.
      dst_d   = (state_q == StBurst) ? dst_q + (hdr_inc0_q ? 32'd0 : Stride) : hdr_dst_q;
    end
  end

  always_ff @(posedge txo_lclk or posedge reset) begin
    if (reset) begin
      tx_q        <= '0;
      state_q     <= StIdle;
      hdr_write_q <= 1'b0;
      hdr_dm_q    <= '0;
      hdr_cm_q    <= '0;
      hdr_dst_q   <= '0;
      hdr_inc0_q  <= 1'b0;
      access_q    <= 1'b0;
      write_q     <= 1'b0;
      dm_q        <= '0;
      cm_q        <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      data_q      <= '0;
      ferr_q      <= 1'b0;
    end else begin
      tx_q        <= tx_in;
      state_q     <= state_d;
      hdr_write_q <= hdr_write_d;
      hdr_dm_q    <= hdr_dm_d;
      hdr_cm_q    <= hdr_cm_d;
      hdr_dst_q   <= hdr_dst_d;
      hdr_inc0_q  <= hdr_inc0_d;
      access_q    <= access_d;
      write_q     <= write_d;
      dm_q        <= dm_d;
      cm_q        <= cm_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      data_q      <= data_d;
      ferr_q      <= ferr_d;
    end
  end

  assign rxo_emesh_access   = access_q;
  assign rxo_emesh_write    = write_q;
  assign rxo_emesh_datamode = dm_q;
  assign rxo_emesh_ctrlmode = cm_q;
  assign rxo_emesh_dstaddr  = dst_q;
  assign rxo_emesh_srcaddr  = src_q;
  assign rxo_emesh_data     = data_q;
  assign frame_err          = ferr_q;

`ifdef ELINK_RXO_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  // Clear wins over a coincident violation.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (viol && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge txo_lclk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_ewrapper_link_rxo_loopback.sv
// Self-checking bench for ewrapper_link_rxo_loopback: transaction-level reference model,
// per-cycle compare, directed literal cases and a randomized frame stream.
module tb_ewrapper_link_rxo_loopback;

  localparam int unsigned Stride = 8;
  localparam int unsigned ErrW   = 2;
  localparam logic [ErrW-1:0] ErrMax = {ErrW{1'b1}};
`ifdef ELINK_RXO_ERRCNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic            txo_lclk = 1'b0;
  logic            reset    = 1'b0;
  logic [71:0]     tx_in    = '0;
  logic            err_clr  = 1'b0;
  logic            rxo_emesh_access;
  logic            rxo_emesh_write;
  logic [1:0]      rxo_emesh_datamode;
  logic [3:0]      rxo_emesh_ctrlmode;
  logic [31:0]     rxo_emesh_dstaddr;
  logic [31:0]     rxo_emesh_srcaddr;
  logic [31:0]     rxo_emesh_data;
  logic            frame_err;
  logic [ErrW-1:0] err_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n_acc  = 0;
  int n_ferr = 0;
  logic [31:0] got_dst[$];

  logic [31:0] exp_burst [4] = '{32'h0000_1000, 32'h0000_1008, 32'h0000_1010, 32'h0000_1018};
  logic [31:0] exp_wrap  [5] = '{32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_4000, 32'h0000_4000,
                                 32'h0000_4000};

  always #5 txo_lclk = ~txo_lclk;

  ewrapper_link_rxo_loopback #(
    .BURST_STRIDE(Stride),
    .ERRCNT_W    (ErrW)
  ) dut (
    .txo_lclk          (txo_lclk),
    .reset             (reset),
    .tx_in             (tx_in),
    .err_clr           (err_clr),
    .rxo_emesh_access  (rxo_emesh_access),
    .rxo_emesh_write   (rxo_emesh_write),
    .rxo_emesh_datamode(rxo_emesh_datamode),
    .rxo_emesh_ctrlmode(rxo_emesh_ctrlmode),
    .rxo_emesh_dstaddr (rxo_emesh_dstaddr),
    .rxo_emesh_srcaddr (rxo_emesh_srcaddr),
    .rxo_emesh_data    (rxo_emesh_data),
    .frame_err         (frame_err),
    .err_count         (err_count)
  );

  function automatic logic [71:0] pack_word(input logic [7:0] f, input logic [63:0] d);
    logic [71:0] w;
    w[71:64] = f;
    for (int j = 0; j < 8; j++) for (int k = 0; k < 8; k++) w[8*k+j] = d[8*j+k];
    return w;
  endfunction

  function automatic logic [63:0] unpack_word(input logic [71:0] w);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) for (int k = 0; k < 8; k++) d[8*j+k] = w[8*k+j];
    return d;
  endfunction

  function automatic logic [63:0] mk_hdr(input logic wr, input logic [1:0] dm,
                                         input logic [31:0] dst, input logic [3:0] cm,
                                         input logic inc0);
    logic [63:0] d;
    d       = '0;
    d[0]    = 1'b1;
    d[1]    = wr;
    d[3:2]  = dm;
    d[35:4] = dst;
    d[39:36] = cm;
    d[42]   = inc0;
    return d;
  endfunction

  function automatic logic [63:0] mk_data(input logic [31:0] src, input logic [31:0] data);
    return {data, src};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks "header pending" / "in burst" and the beat index; the burst
  // address is derived from the header address and beat number rather than accumulated.
  logic [71:0]     m_pend  = '0;
  bit              m_hdr   = 1'b0;
  bit              m_burst = 1'b0;
  int unsigned     m_beats = 0;
  logic            h_wr    = 1'b0;
  logic [1:0]      h_dm    = '0;
  logic [3:0]      h_cm    = '0;
  logic [31:0]     h_dst   = '0;
  logic            h_inc0  = 1'b0;
  logic            e_access = 1'b0;
  logic            e_ferr  = 1'b0;
  logic            e_wr    = 1'b0;
  logic [1:0]      e_dm    = '0;
  logic [3:0]      e_cm    = '0;
  logic [31:0]     e_dst   = '0;
  logic [31:0]     e_src   = '0;
  logic [31:0]     e_data  = '0;
  logic [ErrW-1:0] e_cnt   = '0;

  task automatic model_clear();
    m_pend = '0; m_hdr = 1'b0; m_burst = 1'b0; m_beats = 0;
    h_wr = 1'b0; h_dm = '0; h_cm = '0; h_dst = '0; h_inc0 = 1'b0;
    e_access = 1'b0; e_ferr = 1'b0; e_wr = 1'b0; e_dm = '0; e_cm = '0;
    e_dst = '0; e_src = '0; e_data = '0; e_cnt = '0;
  endtask

  task automatic model_step();
    logic [7:0]  f;
    logic [63:0] d;
    bit viol;
    bit emit;
    f = m_pend[71:64];
    d = unpack_word(m_pend);
    viol = 1'b0;
    emit = 1'b0;
    case (f)
      8'h3F: begin
        if (!m_hdr && !m_burst && !d[0]) viol = 1'b1;
        else begin
          if (m_hdr) viol = 1'b1;
          h_wr = d[1]; h_dm = d[3:2]; h_dst = d[35:4]; h_cm = d[39:36]; h_inc0 = d[42];
          m_hdr = 1'b1; m_burst = 1'b0;
        end
      end
      8'hFF: begin
        if (m_hdr) begin
          m_beats = 0; emit = 1'b1; m_hdr = 1'b0; m_burst = 1'b1;
        end else if (m_burst) begin
          m_beats++; emit = 1'b1;
        end else viol = 1'b1;
      end
      8'h00: begin
        if (m_hdr) viol = 1'b1;
        m_hdr = 1'b0; m_burst = 1'b0;
      end
      default: begin
        viol = 1'b1; m_hdr = 1'b0; m_burst = 1'b0;
      end
    endcase
    e_access = emit;
    e_ferr   = viol;
    if (emit) begin
      e_wr = h_wr; e_dm = h_dm; e_cm = h_cm;
      e_dst  = h_dst + 32'(h_inc0 ? 0 : m_beats * Stride);
      e_src  = d[31:0];
      e_data = d[63:32];
    end
    if (CntEn) begin
      if (err_clr) e_cnt = '0;
      else if (viol && e_cnt != ErrMax) e_cnt = e_cnt + 1'b1;
    end
    m_pend = tx_in;
  endtask

  initial forever begin
    @(posedge txo_lclk or posedge reset);
    if (reset) model_clear();
    else model_step();
  end

  // Compare process: every falling edge, all outputs against the model.
  initial forever begin
    @(negedge txo_lclk);
    if (chk_en) begin
      check("access",   32'(rxo_emesh_access),   32'(e_access));
      check("frame_err", 32'(frame_err),         32'(e_ferr));
      check("write",    32'(rxo_emesh_write),    32'(e_wr));
      check("datamode", 32'(rxo_emesh_datamode), 32'(e_dm));
      check("ctrlmode", 32'(rxo_emesh_ctrlmode), 32'(e_cm));
      check("dstaddr",  rxo_emesh_dstaddr,       e_dst);
      check("srcaddr",  rxo_emesh_srcaddr,       e_src);
      check("data",     rxo_emesh_data,          e_data);
      check("err_count", 32'(err_count),         32'(e_cnt));
      if (rxo_emesh_access === 1'b1) begin
        n_acc++;
        got_dst.push_back(rxo_emesh_dstaddr);
      end
      if (frame_err === 1'b1) n_ferr++;
    end
  end

  task automatic drive(input logic [7:0] f, input logic [63:0] d, input logic clr);
    @(negedge txo_lclk);
    tx_in   = pack_word(f, d);
    err_clr = clr;
    @(posedge txo_lclk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 64'h0, 1'b0);
  endtask

  task automatic assert_reset();
    #2;
    reset   = 1'b1;
    tx_in   = '0;
    err_clr = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge txo_lclk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int a0;
    int f0;
    int r;
    logic [7:0]  fr;
    logic [63:0] dw;

    #3 reset = 1'b1;
    #1;
    check("rst_access", 32'(rxo_emesh_access), 32'h0);
    check("rst_dst",    rxo_emesh_dstaddr,     32'h0);
    check("rst_cnt",    32'(err_count),        32'h0);
    chk_en = 1'b1;
    release_reset();

    // Single write, latency 2 after the data word is sampled.
    drive(8'h3F, mk_hdr(1'b1, 2'd2, 32'h8000_0010, 4'h0, 1'b0), 1'b0);
    drive(8'hFF, mk_data(32'h1234_5678, 32'hDEAD_BEEF), 1'b0);
    #1 check("sw_early", 32'(rxo_emesh_access), 32'h0);
    idle(1);
    #1;
    check("sw_access", 32'(rxo_emesh_access),   32'h1);
    check("sw_write",  32'(rxo_emesh_write),    32'h1);
    check("sw_dm",     32'(rxo_emesh_datamode), 32'h2);
    check("sw_dst",    rxo_emesh_dstaddr,       32'h8000_0010);
    check("sw_src",    rxo_emesh_srcaddr,       32'h1234_5678);
    check("sw_data",   rxo_emesh_data,          32'hDEAD_BEEF);
    idle(2);

    // Burst with stride 8.
    got_dst.delete();
    drive(8'h3F, mk_hdr(1'b1, 2'd3, 32'h0000_1000, 4'h0, 1'b0), 1'b0);
    repeat (4) drive(8'hFF, mk_data($urandom, $urandom), 1'b0);
    idle(3);
    check("burst_n", 32'(got_dst.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got_dst.size()) check("burst_dst", got_dst[i], exp_burst[i]);

    // Address wrap, then header straight after a burst with inc0 set.
    got_dst.delete();
    f0 = n_ferr;
    drive(8'h3F, mk_hdr(1'b0, 2'd2, 32'hFFFF_FFF8, 4'h5, 1'b0), 1'b0);
    repeat (2) drive(8'hFF, mk_data($urandom, $urandom), 1'b0);
    drive(8'h3F, mk_hdr(1'b1, 2'd1, 32'h0000_4000, 4'hA, 1'b1), 1'b0);
    repeat (3) drive(8'hFF, mk_data($urandom, $urandom), 1'b0);
    idle(3);
    check("wrap_n", 32'(got_dst.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < got_dst.size()) check("wrap_dst", got_dst[i], exp_wrap[i]);
    check("wrap_noerr", 32'(n_ferr - f0), 32'd0);

    // Violations: FF in idle, header then idle, unknown frame.
    assert_reset();
    release_reset();
    a0 = n_acc;
    f0 = n_ferr;
    drive(8'hFF, mk_data($urandom, $urandom), 1'b0);
    drive(8'h3F, mk_hdr(1'b1, 2'd0, 32'h0000_0040, 4'h0, 1'b0), 1'b0);
    idle(1);
    drive(8'h0F, 64'h0123_4567_89AB_CDEF, 1'b0);
    idle(2);
    #1;
    check("viol_ferr", 32'(n_ferr - f0), 32'd3);
    check("viol_acc",  32'(n_acc - a0),  32'd0);
    check("viol_cnt",  32'(err_count),   CntEn ? 32'd3 : 32'd0);

    // Saturation and clear.
    assert_reset();
    release_reset();
    repeat (5) drive(8'hFF, 64'h0, 1'b0);
    idle(2);
    #1 check("sat_cnt", 32'(err_count), CntEn ? 32'd3 : 32'd0);
    drive(8'h00, 64'h0, 1'b1);
    idle(1);
    #1 check("clr_cnt", 32'(err_count), 32'd0);

    // Reset in the middle of a burst.
    drive(8'h3F, mk_hdr(1'b1, 2'd2, 32'h0000_2000, 4'h3, 1'b0), 1'b0);
    repeat (3) drive(8'hFF, mk_data(32'hAAAA_0000, 32'h5555_1111), 1'b0);
    #1;
    check("mid_access", 32'(rxo_emesh_access), 32'h1);
    check("mid_dst",    rxo_emesh_dstaddr,     32'h0000_2008);
    assert_reset();
    check("rstmid_access", 32'(rxo_emesh_access), 32'h0);
    check("rstmid_dst",    rxo_emesh_dstaddr,     32'h0);
    check("rstmid_data",   rxo_emesh_data,        32'h0);
    release_reset();
    a0 = n_acc;
    f0 = n_ferr;
    drive(8'hFF, mk_data(32'hAAAA_0001, 32'h5555_2222), 1'b0);
    idle(2);
    check("post_rst_ferr", 32'(n_ferr - f0), 32'd1);
    check("post_rst_acc",  32'(n_acc - a0),  32'd0);

    // Randomized frame stream with occasional clears and resets.
    a0 = n_acc;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 10) fr = 8'h00;
      else if (r < 40) fr = 8'h3F;
      else if (r < 90) fr = 8'hFF;
      else begin
        fr = 8'($urandom);
        if (fr == 8'h00 || fr == 8'h3F || fr == 8'hFF) fr = 8'h5A;
      end
      dw = {$urandom, $urandom};
      if (fr == 8'h3F) dw[0] = ($urandom_range(0, 7) != 0);
      drive(fr, dw, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        release_reset();
      end
    end
    idle(3);
    check("rand_acc_seen", 32'(n_acc > a0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
